// File: rtl/psum_row_collector_pkg.sv
// Shared DLA definitions for the PE-row partial-sum collector: sizes, lane
// grouping modes, element types and the collector FSM states.
package psum_row_collector_pkg;

  localparam int DLA_LANES  = 16;
  localparam int DLA_PROD_W = 16;
  localparam int DLA_ACC_W  = 24;

  typedef enum logic [1:0] {
    MODE_1X1 = 2'd0,
    MODE_G3  = 2'd1,
    MODE_G5  = 2'd2
  } mode_e;

  typedef logic signed [DLA_PROD_W-1:0] prod_t;
  typedef logic signed [DLA_ACC_W-1:0]  psum_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

endpackage

// File: rtl/psum_row_collector_if.sv
// Product stream in, partial-sum stream out; slave is the collector side,
// master is the PE row plus writeback side.
interface psum_row_collector_if
  import psum_row_collector_pkg::*;
#(
  parameter int LANES  = DLA_LANES,
  parameter int PROD_W = DLA_PROD_W,
  parameter int ACC_W  = DLA_ACC_W
);
  logic signed [PROD_W-1:0] product [LANES];
  logic                     prod_valid;
  logic                     prod_ready;
  logic signed [ACC_W-1:0]  psum [LANES];
  logic                     psum_valid;
  logic                     psum_ready;

  modport master (
    output product, prod_valid, psum_ready,
    input  prod_ready, psum, psum_valid
  );

  modport slave (
    input  product, prod_valid, psum_ready,
    output prod_ready, psum, psum_valid
  );
endinterface

// File: rtl/psum_row_collector_reducer.sv
// Combinational lane grouping: passes lanes through or sums groups of 3 or 5
// lanes at full precision; groups beyond the last whole group read as 0.
module psum_lane_reducer
  import psum_row_collector_pkg::*;
#(
  parameter int LANES  = DLA_LANES,
  parameter int PROD_W = DLA_PROD_W,
  parameter int RED_W  = DLA_PROD_W + 3
) (
  input  logic [1:0]               mode,
  input  logic signed [PROD_W-1:0] product [LANES],
  output logic signed [RED_W-1:0]  red [LANES]
);
  localparam int G3 = LANES / 3;
  localparam int G5 = LANES / 5;

  logic signed [RED_W-1:0] lane_ext [LANES];
  logic signed [RED_W-1:0] sum3 [G3];
  logic signed [RED_W-1:0] sum5 [G5];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_ext
      assign lane_ext[gi] = RED_W'(product[gi]);
    end
    for (gi = 0; gi < G3; gi++) begin : g_sum3
      assign sum3[gi] = lane_ext[3*gi] + lane_ext[3*gi+1] + lane_ext[3*gi+2];
    end
    for (gi = 0; gi < G5; gi++) begin : g_sum5
      assign sum5[gi] = lane_ext[5*gi] + lane_ext[5*gi+1] + lane_ext[5*gi+2]
                      + lane_ext[5*gi+3] + lane_ext[5*gi+4];
    end
  endgenerate

  // Reserved mode 3 falls through to the one-to-one mapping.
  always_comb begin
    for (int g = 0; g < LANES; g++) red[g] = '0;
    case (mode)
      MODE_G3: for (int g = 0; g < G3; g++) red[g] = sum3[g];
      MODE_G5: for (int g = 0; g < G5; g++) red[g] = sum5[g];
      default: for (int g = 0; g < LANES; g++) red[g] = lane_ext[g];
    endcase
  end

endmodule

// File: rtl/psum_row_collector.sv
// Accumulates num_acc reduced product vectors into saturating partial sums
// and hands the finished vector out through a one-entry output register.
module psum_row_collector
  import psum_row_collector_pkg::*;
#(
  parameter int LANES  = DLA_LANES,
  parameter int PROD_W = DLA_PROD_W,
  parameter int ACC_W  = DLA_ACC_W,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] num_acc,
  output logic             busy,
  psum_row_collector_if.slave bus
);
  localparam int RED_W = PROD_W + 3;

  state_e                   state_reg, state_next;
  logic [1:0]               mode_reg;
  logic [CNT_W-1:0]         num_acc_reg;
  logic [CNT_W-1:0]         count_reg;
  logic signed [ACC_W-1:0]  acc_reg  [LANES];
  logic signed [ACC_W-1:0]  acc_next [LANES];
  logic signed [ACC_W-1:0]  psum_reg [LANES];
  logic                     psum_valid_reg;
  logic signed [PROD_W-1:0] prod_lane [LANES];
  logic signed [RED_W-1:0]  red [LANES];
  logic                     final_beat;
  logic                     prod_ready;
  logic                     start_pass;
  logic                     accept;

  assign prod_lane = bus.product;

  psum_lane_reducer #(
    .LANES  (LANES),
    .PROD_W (PROD_W),
    .RED_W  (RED_W)
  ) u_reducer (
    .mode    (mode_reg),
    .product (prod_lane),
    .red     (red)
  );

  // One guard bit catches overflow; clamp toward the sign of the true sum.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_sat
      logic signed [ACC_W:0] wide;
      assign wide = (ACC_W+1)'(acc_reg[gi]) + (ACC_W+1)'(red[gi]);
      assign acc_next[gi] = (wide[ACC_W] == wide[ACC_W-1]) ? wide[ACC_W-1:0]
                          : {wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    prod_ready = 1'b0;
    busy       = 1'b0;
    start_pass = 1'b0;
    final_beat = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start && (num_acc != '0)) begin
          start_pass = 1'b1;
          state_next = ST_ACC;
        end
      end
      ST_ACC: begin
        busy       = 1'b1;
        final_beat = (count_reg == num_acc_reg - CNT_W'(1));
        // A slot being drained this same cycle counts as free.
        prod_ready = !(final_beat && psum_valid_reg && !bus.psum_ready);
        if (bus.prod_valid && prod_ready && final_beat) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign accept = bus.prod_valid && prod_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      mode_reg       <= '0;
      num_acc_reg    <= '0;
      count_reg      <= '0;
      psum_valid_reg <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        acc_reg[i]  <= '0;
        psum_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      if (start_pass) begin
        mode_reg    <= mode;
        num_acc_reg <= num_acc;
        count_reg   <= '0;
        for (int i = 0; i < LANES; i++) acc_reg[i] <= '0;
      end else if (accept) begin
        count_reg <= count_reg + CNT_W'(1);
        acc_reg   <= acc_next;
      end
      if (accept && final_beat) begin
        psum_reg       <= acc_next;
        psum_valid_reg <= 1'b1;
      end else if (psum_valid_reg && bus.psum_ready) begin
        psum_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.prod_ready = prod_ready;
  assign bus.psum_valid = psum_valid_reg;
  assign bus.psum       = psum_reg;

endmodule

// File: tb/tb_psum_row_collector.sv
// Directed bench for psum_row_collector: grouping modes, saturation,
// output backpressure, ignored inputs and asynchronous reset mid-pass.
module tb_psum_row_collector;
  import psum_row_collector_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       start = 1'b0;
  logic [7:0] num_acc = 8'd0;
  logic       busy;
  int         tests = 0;
  int         fails = 0;
  int         m1_exp [5] = '{6, 15, 24, 33, 42};

  psum_row_collector_if bus ();

  psum_row_collector dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .start   (start),
    .num_acc (num_acc),
    .busy    (busy),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] got, input longint exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input int ngrp, input longint val);
    for (int i = 0; i < DLA_LANES; i++)
      chk($sformatf("%s[%0d]", tag, i), 64'(bus.psum[i]), (i < ngrp) ? val : 0);
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < DLA_LANES; i++) bus.product[i] = DLA_PROD_W'(v);
  endtask

  task automatic do_start(input logic [1:0] m, input logic [7:0] n);
    mode    = m;
    num_acc = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    $display("[TB] start mode=%0d num_acc=%0d busy=%0b", m, n, busy);
  endtask

  initial begin
    bus.prod_valid = 1'b0;
    bus.psum_ready = 1'b0;
    set_all(0);

    // Reset state
    tick();
    chk("rst_prod_ready", 64'(bus.prod_ready), 0);
    chk("rst_psum_valid", 64'(bus.psum_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk_vec("rst_psum", 0, 0);
    rst = 1'b1;
    tick();

    // start with num_acc=0 is ignored
    do_start(MODE_1X1, 8'd0);
    chk("zero_n_busy", 64'(busy), 0);
    chk("zero_n_ready", 64'(bus.prod_ready), 0);

    // Mode 0, 4 accepts of 100; a start mid-pass must not restart it
    bus.psum_ready = 1'b1;
    do_start(MODE_1X1, 8'd4);
    chk("m0_busy", 64'(busy), 1);
    chk("m0_ready", 64'(bus.prod_ready), 1);
    set_all(100);
    bus.prod_valid = 1'b1;
    tick();
    mode = MODE_G3; num_acc = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("m0_not_yet_valid", 64'(bus.psum_valid), 0);
    chk("m0_still_busy", 64'(busy), 1);
    tick();
    chk("m0_valid", 64'(bus.psum_valid), 1);
    chk("m0_busy_done", 64'(busy), 0);
    chk("m0_ready_idle", 64'(bus.prod_ready), 0);
    chk_vec("m0_psum", 16, 400);
    $display("[TB] result mode=0 psum0=%0d", bus.psum[0]);
    bus.prod_valid = 1'b0;
    tick();
    chk("m0_valid_drop", 64'(bus.psum_valid), 0);
    chk("m0_psum_hold", 64'(bus.psum[3]), 400);

    // Mode 1, one vector of 1..16, with prod_valid gaps first
    do_start(MODE_G3, 8'd1);
    set_all(1234);
    tick();
    tick();
    chk("gap_busy", 64'(busy), 1);
    chk("gap_no_valid", 64'(bus.psum_valid), 0);
    for (int i = 0; i < DLA_LANES; i++) bus.product[i] = DLA_PROD_W'(i + 1);
    bus.prod_valid = 1'b1;
    tick();
    bus.prod_valid = 1'b0;
    chk("m1_valid", 64'(bus.psum_valid), 1);
    for (int i = 0; i < DLA_LANES; i++)
      chk($sformatf("m1_psum[%0d]", i), 64'(bus.psum[i]), (i < 5) ? m1_exp[i] : 0);
    $display("[TB] result mode=1 psum4=%0d", bus.psum[4]);
    tick();

    // Mode 2, 255 vectors, positive then negative saturation
    do_start(MODE_G5, 8'd255);
    set_all(32767);
    bus.prod_valid = 1'b1;
    repeat (254) tick();
    chk("m2p_not_yet", 64'(bus.psum_valid), 0);
    tick();
    bus.prod_valid = 1'b0;
    chk("m2p_valid", 64'(bus.psum_valid), 1);
    chk_vec("m2p_psum", 3, 8388607);
    $display("[TB] result mode=2 psum0=%0d", bus.psum[0]);
    tick();
    do_start(MODE_G5, 8'd255);
    set_all(-32768);
    bus.prod_valid = 1'b1;
    repeat (255) tick();
    bus.prod_valid = 1'b0;
    chk("m2n_valid", 64'(bus.psum_valid), 1);
    chk_vec("m2n_psum", 3, -8388608);
    $display("[TB] result mode=2 psum0=%0d", bus.psum[0]);
    tick();

    // Backpressure: two num_acc=2 passes with psum_ready low
    bus.psum_ready = 1'b0;
    do_start(MODE_1X1, 8'd2);
    set_all(7);
    bus.prod_valid = 1'b1;
    tick();
    tick();
    bus.prod_valid = 1'b0;
    chk("bp1_valid", 64'(bus.psum_valid), 1);
    chk_vec("bp1_psum", 16, 14);
    do_start(MODE_1X1, 8'd2);
    set_all(9);
    bus.prod_valid = 1'b1;
    tick();
    chk("bp2_final_stall", 64'(bus.prod_ready), 0);
    tick();
    tick();
    chk("bp2_still_stall", 64'(bus.prod_ready), 0);
    chk("bp2_busy", 64'(busy), 1);
    chk("bp2_hold_old", 64'(bus.psum[5]), 14);
    bus.psum_ready = 1'b1;
    #1;
    chk("bp2_ready_freed", 64'(bus.prod_ready), 1);
    tick();
    bus.prod_valid = 1'b0;
    chk("bp2_valid", 64'(bus.psum_valid), 1);
    chk("bp2_idle", 64'(busy), 0);
    chk_vec("bp2_psum", 16, 18);
    $display("[TB] result backpressure psum0=%0d", bus.psum[0]);
    tick();
    chk("bp2_drained", 64'(bus.psum_valid), 0);

    // Reset mid-pass with a pending result
    bus.psum_ready = 1'b0;
    do_start(MODE_1X1, 8'd1);
    set_all(5);
    bus.prod_valid = 1'b1;
    tick();
    bus.prod_valid = 1'b0;
    chk("pend_valid", 64'(bus.psum_valid), 1);
    do_start(MODE_1X1, 8'd5);
    set_all(3);
    bus.prod_valid = 1'b1;
    repeat (3) tick();
    chk("mid_busy", 64'(busy), 1);
    rst = 1'b0;
    #1;
    chk("arst_ready", 64'(bus.prod_ready), 0);
    chk("arst_busy", 64'(busy), 0);
    chk("arst_valid", 64'(bus.psum_valid), 0);
    chk_vec("arst_psum", 0, 0);
    bus.prod_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    bus.psum_ready = 1'b1;
    do_start(MODE_1X1, 8'd2);
    set_all(1);
    bus.prod_valid = 1'b1;
    tick();
    tick();
    bus.prod_valid = 1'b0;
    chk("post_rst_valid", 64'(bus.psum_valid), 1);
    chk_vec("post_rst_psum", 16, 2);
    $display("[TB] result after reset psum0=%0d", bus.psum[0]);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
